output_seg_led_shift: RTL and testbench
=======================================

# output_seg_led_shift

Serial output driver for the board's eight-digit seven-segment display and sixteen LEDs. Both hang off external serial-in/parallel-out shift-register chains. On an update request, the block latches a 32-bit hex value, per-digit decimal-point and blank masks, and a 16-bit LED pattern. It encodes the digits to active-low segment bytes, shifts both chains out in parallel, and pulses the load strobes. It is the output counterpart of the switch/button input path, sitting between CPU-side display registers and the board pins.

## Interface
- CLK_DIV, 4, clk cycles per half-period of the serial clocks; legal range ≥1
- clk  in  1  system clock, all logic on rising edge
- RSTN  in  1  asynchronous, active-low reset
- disp_data  in  32  eight hex digits; [31:28] is digit 7 (leftmost)
- point  in  8  decimal point per digit, 1 = lit; bit i ↔ digit i
- blank  in  8  1 = digit i fully off (overrides data and point)
- led_data  in  16  1 = LED lit; bit 15 leftmost
- update  in  1  request to send; level-sampled each cycle
- busy  out  1  high while a frame is in progress
- seg_clk  out  1  segment chain shift clock; external registers shift on its rising edge
- seg_dout  out  1  segment chain serial data
- seg_load  out  1  segment chain output-latch strobe, active high
- seg_clr_n  out  1  segment chain clear, active low
- led_clk, led_dout, led_load, led_clr_n  out  1 each  same meanings for the LED chain

## Operation
- Segment encoding, per digit, is one byte {dp,g,f,e,d,c,b,a}, active low.
  - Hex 0–F map to C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
  - point[i]=1 clears bit 7.
  - blank[i]=1 forces FF.
- Frame order:
  - Segment frame is 64 bits: digit 7 byte first, MSB first, digit 0 bit 0 last.
  - LED frame is 16 bits of ~led_data (active low), bit 15 first.
- States: IDLE, SHIFT, LATCH.
- IDLE:
  - seg_clk=led_clk=0, load strobes 0, busy=0.
  - If update=1 or pending=1: sample all data inputs into the shift registers, clear pending, and go to SHIFT with bit index 0.
- SHIFT, one bit period = 2×CLK_DIV cycles:
  - First CLK_DIV cycles: clocks low.
  - Last CLK_DIV cycles: seg_clk high.
  - Data changes only at the start of a bit period, with clocks low.
  - led_clk pulses together with seg_clk for bit periods 0–15 only, then holds 0. led_dout holds its last bit afterwards.
  - After bit 63's period, go to LATCH.
- LATCH: seg_load=led_load=1 for CLK_DIV cycles, then IDLE.
- update=1 seen while busy sets pending. One pending request is remembered; extra ones merge. Data is resampled when the new frame starts, not when the request arrived.
- Inputs changing mid-frame do not affect the frame in flight.
- seg_clr_n and led_clr_n are 0 while RSTN=0 and 1 from the first clk edge after release.
- Reset mid-frame: outputs go to reset values immediately and pending is cleared. No partial load strobe is issued.

## Timing
- Reset values:
  - busy, all clocks, douts and loads = 0; clr_n = 0.
  - State = IDLE, pending = 0, shift registers = 0.
- Latency:
  - update sampled high in IDLE at edge N → busy=1, seg_dout=frame bit 63 from edge N+1.
  - First seg_clk rise at N+1+CLK_DIV.
- Frame length: busy high for exactly 129×CLK_DIV cycles (128×CLK_DIV shift plus CLK_DIV latch).
- busy falls and load strobes fall on the same edge.
- Back-to-back frames: with pending=1 at frame end, the state spends one cycle in IDLE with busy=0, then busy rises again.
- Counters:
  - Half-period counter is ⌈log2(CLK_DIV)⌉ bits, wrapping at CLK_DIV−1.
  - Bit counter is 6 bits, terminal count 63, no overflow.

## Test plan
- Reset:
  - Stimulus: assert RSTN=0 mid-SHIFT, release.
  - Required: all outputs reset values during reset; clr_n=1 one edge after release; no load pulse.
- Single frame:
  - Stimulus: CLK_DIV=2, disp_data=0x0123ABCF, point=0x01, blank=0x00, led_data=0x8001, one-cycle update.
  - Required: busy high 258 cycles; exactly 64 seg_clk and 16 led_clk rises; one 2-cycle load pulse on each chain.
  - Required segment bits captured at seg_clk rises: C0 F9 A4 B0 88 83 C6 0E.
  - Required LED bits captured at led_clk rises: 0x7FFE.
- Blank and point:
  - Stimulus: blank=0xF0, point=0xFF, disp_data=0x88888888.
  - Required: bytes FF,FF,FF,FF,00,00,00,00.
- Request during busy:
  - Stimulus: update pulses at cycles 10 and 40 of a frame; led_data changed to 0x00FF before frame end.
  - Required: exactly one extra frame follows after one idle cycle; it carries the new led_data (LED bits 0xFF00).
- Input change mid-frame:
  - Stimulus: disp_data altered during SHIFT.
  - Required: captured bytes match the value sampled at frame start.
- CLK_DIV=1:
  - Required: seg_clk toggles every cycle during SHIFT; busy is 129 cycles; the frame is correct.

Source files
------------

// File: rtl/output_seg_led_shift.sv
// rtl/output_seg_led_shift.sv - serial driver for the 8-digit seven-segment and 16-LED shift-register chains
// Latches a frame on update, shifts both chains out in parallel, then strobes the output latches.
module output_seg_led_shift #(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        RSTN,
   input  logic [31:0] disp_data,
   input  logic [7:0]  point,
   input  logic [7:0]  blank,
   input  logic [15:0] led_data,
   input  logic        update,
   output logic        busy,
   output logic        seg_clk,
   output logic        seg_dout,
   output logic        seg_load,
   output logic        seg_clr_n,
   output logic        led_clk,
   output logic        led_dout,
   output logic        led_load,
   output logic        led_clr_n
);

   localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [HW-1:0] CNT_MAX = HW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [HW-1:0] cnt_q, cnt_d;
   logic        phase_q, phase_d;
   logic [5:0]  bit_idx_q, bit_idx_d;
   logic [63:0] seg_sr_q, seg_sr_d;
   logic [15:0] led_sr_q, led_sr_d;
   logic        pending_q, pending_d;
   logic        busy_q, busy_d;
   logic        seg_clk_q, seg_clk_d;
   logic        led_clk_q, led_clk_d;
   logic        load_q, load_d;
   logic        clr_n_q, clr_n_d;
   logic [63:0] seg_frame;

   function automatic logic [7:0] seg_code(input logic [3:0] hex, input logic dp, input logic blk);
      logic [7:0] code;
      case (hex)
         4'h0: code = 8'hC0;
         4'h1: code = 8'hF9;
         4'h2: code = 8'hA4;
         4'h3: code = 8'hB0;
         4'h4: code = 8'h99;
         4'h5: code = 8'h92;
         4'h6: code = 8'h82;
         4'h7: code = 8'hF8;
         4'h8: code = 8'h80;
         4'h9: code = 8'h90;
         4'hA: code = 8'h88;
         4'hB: code = 8'h83;
         4'hC: code = 8'hC6;
         4'hD: code = 8'hA1;
         4'hE: code = 8'h86;
         default: code = 8'h8E;
      endcase
      if (dp) code[7] = 1'b0;
      if (blk) code = 8'hFF;
      return code;
   endfunction

   // Digit 7 lands in the top byte so it leaves the chain first.
   always_comb begin
      seg_frame = '0;
      for (int i = 0; i < 8; i++) begin
         seg_frame[8*i +: 8] = seg_code(disp_data[4*i +: 4], point[i], blank[i]);
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      phase_d   = phase_q;
      bit_idx_d = bit_idx_q;
      seg_sr_d  = seg_sr_q;
      led_sr_d  = led_sr_q;
      pending_d = pending_q;
      busy_d    = busy_q;
      seg_clk_d = seg_clk_q;
      led_clk_d = led_clk_q;
      load_d    = load_q;
      clr_n_d   = 1'b1;

      case (state_q)
         IDLE: begin
            seg_clk_d = 1'b0;
            led_clk_d = 1'b0;
            load_d    = 1'b0;
            busy_d    = 1'b0;
            if (update || pending_q) begin
               seg_sr_d  = seg_frame;
               led_sr_d  = ~led_data;
               pending_d = 1'b0;
               state_d   = SHIFT;
               cnt_d     = '0;
               phase_d   = 1'b0;
               bit_idx_d = '0;
               busy_d    = 1'b1;
            end
         end
         SHIFT: begin
            if (update) pending_d = 1'b1;
            if (cnt_q == CNT_MAX) begin
               cnt_d = '0;
               if (!phase_q) begin
                  phase_d   = 1'b1;
                  seg_clk_d = 1'b1;
                  led_clk_d = (bit_idx_q < 6'd16);
               end else begin
                  phase_d   = 1'b0;
                  seg_clk_d = 1'b0;
                  led_clk_d = 1'b0;
                  if (bit_idx_q == 6'd63) begin
                     state_d = LATCH;
                     load_d  = 1'b1;
                  end else begin
                     bit_idx_d = bit_idx_q + 6'd1;
                     seg_sr_d  = {seg_sr_q[62:0], 1'b0};
                     // LED chain stops after its 16th bit so led_dout keeps bit 0.
                     if (bit_idx_q < 6'd15) led_sr_d = {led_sr_q[14:0], 1'b0};
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LATCH: begin
            if (update) pending_d = 1'b1;
            if (cnt_q == CNT_MAX) begin
               cnt_d   = '0;
               state_d = IDLE;
               load_d  = 1'b0;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            load_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         phase_q   <= 1'b0;
         bit_idx_q <= '0;
         seg_sr_q  <= '0;
         led_sr_q  <= '0;
         pending_q <= 1'b0;
         busy_q    <= 1'b0;
         seg_clk_q <= 1'b0;
         led_clk_q <= 1'b0;
         load_q    <= 1'b0;
         clr_n_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         bit_idx_q <= bit_idx_d;
         seg_sr_q  <= seg_sr_d;
         led_sr_q  <= led_sr_d;
         pending_q <= pending_d;
         busy_q    <= busy_d;
         seg_clk_q <= seg_clk_d;
         led_clk_q <= led_clk_d;
         load_q    <= load_d;
         clr_n_q   <= clr_n_d;
      end
   end

   assign busy      = busy_q;
   assign seg_clk   = seg_clk_q;
   assign seg_dout  = seg_sr_q[63];
   assign seg_load  = load_q;
   assign seg_clr_n = clr_n_q;
   assign led_clk   = led_clk_q;
   assign led_dout  = led_sr_q[15];
   assign led_load  = load_q;
   assign led_clr_n = clr_n_q;

endmodule

// File: tb/tb_output_seg_led_shift.sv
// tb/tb_output_seg_led_shift.sv - scoreboard bench for output_seg_led_shift at CLK_DIV=2 and CLK_DIV=1
module tb_output_seg_led_shift;

   typedef struct {
      logic [63:0] seg;
      logic [15:0] led;
      int nseg;
      int nled;
      int busy;
      int ld;
      int lld;
      int first_rise;
      int gap;
   } frame_t;

   typedef struct {
      logic [63:0] seg;
      logic [15:0] led;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [31:0] disp_data = '0;
   logic [7:0]  point = '0;
   logic [7:0]  blank = '0;
   logic [15:0] led_data = '0;
   logic upd2 = 1'b0;
   logic upd1 = 1'b0;

   logic [1:0] busy_w, seg_clk_w, seg_dout_w, seg_load_w, seg_clr_w;
   logic [1:0] led_clk_w, led_dout_w, led_load_w, led_clr_w;

   int checks = 0;
   int failures = 0;

   exp_t   exp2[$];
   exp_t   exp1[$];
   frame_t res2[$];
   frame_t res1[$];

   frame_t acc [2];
   logic [1:0] pb = '0, psc = '0, plc = '0, pld = '0;
   int idle_cnt [2] = '{0, 0};
   int load_rises [2] = '{0, 0};

   localparam logic [7:0] HEXSEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   always #5 clk = ~clk;

   output_seg_led_shift #(.CLK_DIV(2)) dut2 (
      .clk(clk), .RSTN(rst_n), .disp_data(disp_data), .point(point), .blank(blank),
      .led_data(led_data), .update(upd2), .busy(busy_w[0]), .seg_clk(seg_clk_w[0]),
      .seg_dout(seg_dout_w[0]), .seg_load(seg_load_w[0]), .seg_clr_n(seg_clr_w[0]),
      .led_clk(led_clk_w[0]), .led_dout(led_dout_w[0]), .led_load(led_load_w[0]),
      .led_clr_n(led_clr_w[0])
   );

   output_seg_led_shift #(.CLK_DIV(1)) dut1 (
      .clk(clk), .RSTN(rst_n), .disp_data(disp_data), .point(point), .blank(blank),
      .led_data(led_data), .update(upd1), .busy(busy_w[1]), .seg_clk(seg_clk_w[1]),
      .seg_dout(seg_dout_w[1]), .seg_load(seg_load_w[1]), .seg_clr_n(seg_clr_w[1]),
      .led_clk(led_clk_w[1]), .led_dout(led_dout_w[1]), .led_load(led_load_w[1]),
      .led_clr_n(led_clr_w[1])
   );

   function automatic logic [63:0] exp_seg(input logic [31:0] dd, input logic [7:0] pt, input logic [7:0] bl);
      logic [7:0] b;
      logic [63:0] f;
      f = '0;
      for (int i = 0; i < 8; i++) begin
         b = HEXSEG[dd[4*i +: 4]];
         if (pt[i]) b[7] = 1'b0;
         if (bl[i]) b = 8'hFF;
         f[8*i +: 8] = b;
      end
      return f;
   endfunction

   // Frame monitor: sampled on the falling edge, bits captured where the serial clocks rise.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            acc[d] = '{default: 0};
            pb[d] = 1'b0; psc[d] = 1'b0; plc[d] = 1'b0; pld[d] = 1'b0;
            idle_cnt[d] = 0;
         end else begin
            if (busy_w[d]) begin
               if (!pb[d]) begin
                  acc[d] = '{default: 0};
                  acc[d].gap = idle_cnt[d];
               end
               acc[d].busy++;
               if (seg_clk_w[d] && !psc[d]) begin
                  acc[d].seg = {acc[d].seg[62:0], seg_dout_w[d]};
                  acc[d].nseg++;
                  if (acc[d].nseg == 1) acc[d].first_rise = acc[d].busy;
               end
               if (led_clk_w[d] && !plc[d]) begin
                  acc[d].led = {acc[d].led[14:0], led_dout_w[d]};
                  acc[d].nled++;
               end
               if (seg_load_w[d]) acc[d].ld++;
               if (led_load_w[d]) acc[d].lld++;
               idle_cnt[d] = 0;
            end else begin
               if (pb[d]) begin
                  if (d == 0) res2.push_back(acc[d]);
                  else res1.push_back(acc[d]);
               end
               idle_cnt[d]++;
            end
            if (seg_load_w[d] && !pld[d]) load_rises[d]++;
            pb[d] = busy_w[d]; psc[d] = seg_clk_w[d]; plc[d] = led_clk_w[d]; pld[d] = seg_load_w[d];
         end
      end
   end

   task automatic pulse(input int d);
      @(negedge clk);
      if (d == 0) upd2 = 1'b1; else upd1 = 1'b1;
      @(negedge clk);
      upd2 = 1'b0;
      upd1 = 1'b0;
   endtask

   task automatic wait_frame(input int d, input int lim, output frame_t r, output bit ok);
      ok = 1'b0;
      r = '{default: 0};
      for (int i = 0; i < lim; i++) begin
         if (d == 0 && res2.size() > 0) break;
         if (d == 1 && res1.size() > 0) break;
         @(posedge clk);
      end
      if (d == 0 && res2.size() > 0) begin r = res2.pop_front(); ok = 1'b1; end
      if (d == 1 && res1.size() > 0) begin r = res1.pop_front(); ok = 1'b1; end
   endtask

   task automatic test_reset();
      int lr;
      @(negedge clk);
      checks++;
      if ({busy_w, seg_clk_w, seg_dout_w, seg_load_w, led_clk_w, led_dout_w, led_load_w} !== 14'h0) begin
         failures++; $display("FAIL reset_outputs got=%h want=0", {busy_w, seg_clk_w, seg_dout_w, seg_load_w, led_clk_w, led_dout_w, led_load_w});
      end
      checks++;
      if ({seg_clr_w, led_clr_w} !== 4'b0000) begin
         failures++; $display("FAIL reset_clr_n got=%b want=0000", {seg_clr_w, led_clr_w});
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({seg_clr_w, led_clr_w} !== 4'b1111) begin
         failures++; $display("FAIL clr_n_release got=%b want=1111", {seg_clr_w, led_clr_w});
      end
      disp_data = 32'h55AA_1234; led_data = 16'h0F0F;
      pulse(0);
      repeat (30) @(negedge clk);
      pulse(0);
      repeat (5) @(negedge clk);
      lr = load_rises[0];
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy_w[0], seg_clk_w[0], seg_dout_w[0], seg_load_w[0], led_clk_w[0], led_dout_w[0], led_load_w[0], seg_clr_w[0], led_clr_w[0]} !== 9'h0) begin
         failures++; $display("FAIL midframe_reset_outputs got=%b want=0", {busy_w[0], seg_clk_w[0], seg_dout_w[0], seg_load_w[0], led_clk_w[0], led_dout_w[0], led_load_w[0], seg_clr_w[0], led_clr_w[0]});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({seg_clr_w[0], led_clr_w[0]} !== 2'b11) begin
         failures++; $display("FAIL midframe_clr_release got=%b want=11", {seg_clr_w[0], led_clr_w[0]});
      end
      repeat (600) @(negedge clk);
      checks++;
      if (load_rises[0] != lr || res2.size() != 0 || idle_cnt[0] < 600) begin
         failures++; $display("FAIL reset_no_frame loads=%0d want=%0d frames=%0d idle=%0d want>=600", load_rises[0], lr, res2.size(), idle_cnt[0]);
      end
   endtask

   task automatic test_single_frame();
      frame_t r; exp_t e; bit ok; int lr;
      disp_data = 32'h0123_ABCF; point = 8'h01; blank = 8'h00; led_data = 16'h8001;
      exp2.push_back('{seg: 64'hC0F9A4B0_8883C60E, led: 16'h7FFE});
      lr = load_rises[0];
      pulse(0);
      wait_frame(0, 1000, r, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL single_timeout got=none want=frame"); return; end
      e = exp2.pop_front();
      checks++;
      if (r.seg !== e.seg) begin failures++; $display("FAIL single_seg got=%h want=%h", r.seg, e.seg); end
      checks++;
      if (r.led !== e.led) begin failures++; $display("FAIL single_led got=%h want=%h", r.led, e.led); end
      checks++;
      if (r.nseg != 64 || r.nled != 16) begin failures++; $display("FAIL single_clk_rises got=%0d/%0d want=64/16", r.nseg, r.nled); end
      checks++;
      if (r.busy != 258) begin failures++; $display("FAIL single_busy got=%0d want=258", r.busy); end
      checks++;
      if (r.ld != 2 || r.lld != 2 || load_rises[0] - lr != 1) begin
         failures++; $display("FAIL single_load got=%0d/%0d pulses=%0d want=2/2 pulses=1", r.ld, r.lld, load_rises[0] - lr);
      end
      checks++;
      if (r.first_rise != 3) begin failures++; $display("FAIL single_first_rise got=%0d want=3", r.first_rise); end
   endtask

   task automatic test_blank_point();
      frame_t r; exp_t e; bit ok;
      disp_data = 32'h8888_8888; point = 8'hFF; blank = 8'hF0; led_data = 16'hA5C3;
      exp2.push_back('{seg: 64'hFFFFFFFF_00000000, led: 16'h5A3C});
      pulse(0);
      wait_frame(0, 1000, r, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL blank_timeout got=none want=frame"); return; end
      e = exp2.pop_front();
      checks++;
      if (r.seg !== e.seg || r.led !== e.led) begin
         failures++; $display("FAIL blank_point got=%h/%h want=%h/%h", r.seg, r.led, e.seg, e.led);
      end
   endtask

   task automatic test_back_to_back();
      frame_t r; exp_t e; bit ok;
      disp_data = 32'hDEAD_BEEF; point = 8'h10; blank = 8'h00; led_data = 16'h1234;
      exp2.push_back('{seg: exp_seg(32'hDEAD_BEEF, 8'h10, 8'h00), led: 16'hEDCB});
      pulse(0);
      repeat (8) @(negedge clk);
      pulse(0);
      repeat (28) @(negedge clk);
      pulse(0);
      repeat (20) @(negedge clk);
      disp_data = 32'h7654_3210; point = 8'h00; blank = 8'h81; led_data = 16'h00FF;
      exp2.push_back('{seg: exp_seg(32'h7654_3210, 8'h00, 8'h81), led: 16'hFF00});
      for (int k = 0; k < 2; k++) begin
         wait_frame(0, 1000, r, ok);
         checks++;
         if (!ok) begin failures++; $display("FAIL b2b_timeout frame=%0d got=none want=frame", k); return; end
         e = exp2.pop_front();
         checks++;
         if (r.seg !== e.seg || r.led !== e.led) begin
            failures++; $display("FAIL b2b_data frame=%0d got=%h/%h want=%h/%h", k, r.seg, r.led, e.seg, e.led);
         end
         if (k == 1) begin
            checks++;
            if (r.gap != 1 || r.busy != 258) begin
               failures++; $display("FAIL b2b_gap got=%0d busy=%0d want=1 busy=258", r.gap, r.busy);
            end
         end
      end
      repeat (700) @(negedge clk);
      checks++;
      if (res2.size() != 0 || busy_w[0] !== 1'b0) begin
         failures++; $display("FAIL b2b_extra frames=%0d busy=%b want=0/0", res2.size(), busy_w[0]);
      end
   endtask

   task automatic test_midframe_change();
      frame_t r; exp_t e; bit ok;
      disp_data = 32'h0F1E_2D3C; point = 8'h22; blank = 8'h04; led_data = 16'hC001;
      exp2.push_back('{seg: exp_seg(32'h0F1E_2D3C, 8'h22, 8'h04), led: 16'h3FFE});
      pulse(0);
      repeat (50) @(negedge clk);
      disp_data = 32'hFFFF_0000; point = 8'h00; blank = 8'hFF; led_data = 16'h0000;
      wait_frame(0, 1000, r, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL midframe_timeout got=none want=frame"); return; end
      e = exp2.pop_front();
      checks++;
      if (r.seg !== e.seg || r.led !== e.led) begin
         failures++; $display("FAIL midframe_data got=%h/%h want=%h/%h", r.seg, r.led, e.seg, e.led);
      end
   endtask

   task automatic test_clkdiv1();
      frame_t r; exp_t e; bit ok;
      disp_data = 32'h9A0B_C1D2; point = 8'h81; blank = 8'h00; led_data = 16'h6001;
      exp1.push_back('{seg: exp_seg(32'h9A0B_C1D2, 8'h81, 8'h00), led: 16'h9FFE});
      pulse(1);
      wait_frame(1, 500, r, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL div1_timeout got=none want=frame"); return; end
      e = exp1.pop_front();
      checks++;
      if (r.seg !== e.seg || r.led !== e.led) begin
         failures++; $display("FAIL div1_data got=%h/%h want=%h/%h", r.seg, r.led, e.seg, e.led);
      end
      checks++;
      if (r.busy != 129 || r.nseg != 64 || r.nled != 16 || r.ld != 1 || r.first_rise != 2) begin
         failures++; $display("FAIL div1_timing got busy=%0d rises=%0d/%0d load=%0d first=%0d want 129 64/16 1 2",
                              r.busy, r.nseg, r.nled, r.ld, r.first_rise);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_blank_point();
      test_back_to_back();
      test_midframe_change();
      test_clkdiv1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
